// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
// INS_W is also used by the control decoder.
package fetch_pkg;

    localparam int unsigned INS_W            = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack master, instruction register
// with valid/taken handshake to decode, and redirect handling.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | first cycle after reset, no request yet
// S_REQ   | request outstanding at imemAddr, data will be kept
// S_HOLD  | ins holds a live instruction, waiting for insTaken
// S_DRAIN | stale request still outstanding, target latched in tgt_q
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [INS_W-1:0]  imemData,
    output logic [INS_W-1:0]  ins,
    output logic              insValid,
    input  logic              insTaken,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPc
);

    fetch_state_t      state_q, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [ADDR_W-1:0] tgt_q, tgt_nxt;
    logic [INS_W-1:0]  ins_q, ins_nxt;
    logic              req_q, req_nxt;
    logic              valid_q, valid_nxt;

    logic [ADDR_W-1:0] rd_tgt;
    logic [ADDR_W-1:0] pc_inc;

    assign rd_tgt = {redirectPc[ADDR_W-1:2], 2'b00};
    assign pc_inc = pc_q + ADDR_W'(PC_STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            tgt_q   <= RESET_PC;
            ins_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            addr_q  <= addr_nxt;
            tgt_q   <= tgt_nxt;
            ins_q   <= ins_nxt;
            req_q   <= req_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        addr_nxt  = addr_q;
        tgt_nxt   = tgt_q;
        ins_nxt   = ins_q;
        req_nxt   = req_q;
        valid_nxt = valid_q;

        case (state_q)
            S_IDLE: begin
                state_nxt = S_REQ;
                req_nxt   = 1'b1;
                if (redirect) begin
                    pc_nxt   = rd_tgt;
                    addr_nxt = rd_tgt;
                end else begin
                    addr_nxt = pc_q;
                end
            end

            S_REQ: begin
                if (redirect) begin
                    // The request cannot be withdrawn; only move the address once it is acked.
                    if (imemAck) begin
                        pc_nxt   = rd_tgt;
                        addr_nxt = rd_tgt;
                    end else begin
                        tgt_nxt   = rd_tgt;
                        state_nxt = S_DRAIN;
                    end
                end else if (imemAck) begin
                    ins_nxt   = imemData;
                    valid_nxt = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = rd_tgt;
                    addr_nxt  = rd_tgt;
                    req_nxt   = 1'b1;
                    state_nxt = S_REQ;
                end else if (insTaken) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = pc_inc;
                    addr_nxt  = pc_inc;
                    req_nxt   = 1'b1;
                    state_nxt = S_REQ;
                end
            end

            S_DRAIN: begin
                if (imemAck) begin
                    pc_nxt    = redirect ? rd_tgt : tgt_q;
                    addr_nxt  = redirect ? rd_tgt : tgt_q;
                    state_nxt = S_REQ;
                end else if (redirect) begin
                    tgt_nxt = rd_tgt;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                req_nxt   = 1'b0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign imemReq  = req_q;
    assign imemAddr = addr_q;
    assign ins      = ins_q;
    assign insValid = valid_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver runs a transaction-level model and
// queues expected (pc, ins) pairs; a monitor pops them as decode sees new instructions.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] ins;
    logic        insValid;
    logic        insTaken;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirectPc;

    logic        w_reset_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_data;
    logic [31:0] w_ins;
    logic        w_valid;
    logic        w_taken;
    logic [31:0] w_pc;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    bit          w_done = 1'b0;

    assign w_ack  = w_req;
    assign w_data = 32'h0000_1111;

    fetch_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemData  (imemData),
        .ins       (ins),
        .insValid  (insValid),
        .insTaken  (insTaken),
        .pc        (pc),
        .redirect  (redirect),
        .redirectPc(redirectPc)
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk       (clk),
        .reset_n   (w_reset_n),
        .imemReq   (w_req),
        .imemAddr  (w_addr),
        .imemAck   (w_ack),
        .imemData  (w_data),
        .ins       (w_ins),
        .insValid  (w_valid),
        .insTaken  (w_taken),
        .pc        (w_pc),
        .redirect  (w_redirect),
        .redirectPc(w_redirect_pc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h8C22_0004;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sbq[$];

    // Transaction-level view: waiting for the first fetch, waiting on memory, or
    // presenting an instruction. A "discard" fetch is a stale request whose data is dropped.
    typedef enum {M_START, M_FETCH, M_PRESENT} mphase_t;
    mphase_t     ph;
    logic [31:0] exp_addr;
    logic [31:0] stale_addr;
    bit          discard;

    task automatic model_reset();
        ph       = M_START;
        exp_addr = 32'h0;
        discard  = 1'b0;
        sbq.delete();
    endtask

    // Called at a negedge: check request side, drive inputs for the next posedge, advance model.
    task automatic step(input bit rd, input logic [31:0] rdpc, input bit ack, input bit taken);
        bit ack_eff;
        bit keep;
        chk("imemReq", 32'(imemReq), 32'(ph == M_FETCH));
        chk("insValid", 32'(insValid), 32'(ph == M_PRESENT));
        if (ph == M_FETCH)
            chk("imemAddr", imemAddr, discard ? stale_addr : exp_addr);
        ack_eff    = ack && (ph == M_FETCH);
        keep       = ack_eff && !rd && !discard;
        redirect   = rd;
        redirectPc = rdpc;
        imemAck    = ack_eff;
        imemData   = keep ? mem(imemAddr) : 32'hDEAD_BEEF;
        insTaken   = taken;
        case (ph)
            M_START: begin
                if (rd) exp_addr = align(rdpc);
                discard = 1'b0;
                ph      = M_FETCH;
            end
            M_FETCH: begin
                if (rd) begin
                    if (!discard && !ack_eff) begin
                        stale_addr = exp_addr;
                        discard    = 1'b1;
                    end
                    if (ack_eff) discard = 1'b0;
                    exp_addr = align(rdpc);
                end else if (ack_eff) begin
                    if (discard) discard = 1'b0;
                    else begin
                        sbq.push_back('{pc: exp_addr, ins: mem(exp_addr)});
                        ph = M_PRESENT;
                    end
                end
            end
            M_PRESENT: begin
                if (rd) begin
                    exp_addr = align(rdpc);
                    ph       = M_FETCH;
                end else if (taken) begin
                    exp_addr = exp_addr + 32'd4;
                    ph       = M_FETCH;
                end
            end
            default: ph = M_START;
        endcase
        @(negedge clk);
    endtask

    // Monitor: a rising insValid is a new instruction; while held it must not change.
    initial begin
        bit   prev_valid;
        exp_t held;
        prev_valid = 1'b0;
        held       = '{pc: 32'h0, ins: 32'h0};
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (insValid && !prev_valid) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_ins", ins, 32'hxxxx_xxxx);
                    end else begin
                        held = sbq.pop_front();
                        chk("ins", ins, held.ins);
                        chk("pc", pc, held.pc);
                    end
                end else if (insValid) begin
                    chk("hold_ins", ins, held.ins);
                    chk("hold_pc", pc, held.pc);
                end
                prev_valid = insValid;
            end
        end
    end

    // Second instance: PC wraps from 0xFFFFFFFC to 0 with a zero-wait memory.
    initial begin
        logic [31:0] seen[$];
        bit          got_pc;
        got_pc        = 1'b0;
        w_reset_n     = 1'b0;
        w_taken       = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        w_reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (w_req && seen.size() < 3) seen.push_back(w_addr);
            if (w_valid && !got_pc) begin
                chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
                got_pc = 1'b1;
            end
        end
        chk("wrap_valid_seen", 32'(got_pc), 32'd1);
        chk("wrap_req_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("wrap_addr0", seen[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", seen[1], 32'h0000_0000);
            chk("wrap_addr2", seen[2], 32'h0000_0004);
        end
        w_done = 1'b1;
    end

    initial begin
        reset_n    = 1'b0;
        imemAck    = 1'b0;
        imemData   = 32'h0;
        insTaken   = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_imemReq", 32'(imemReq), 32'd0);
        chk("rst_imemAddr", imemAddr, 32'h0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_insValid", 32'(insValid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        reset_n = 1'b1;

        // zero-wait memory, decoder always ready
        repeat (7) step(1'b0, 32'h0, 1'b1, 1'b1);

        // late ack and stalled decoder
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // redirect in hold with simultaneous taken
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // redirect while a request is outstanding, ack two cycles later
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // asynchronous reset mid-request
        #2 reset_n = 1'b0;
        #1;
        chk("arst_imemReq", 32'(imemReq), 32'd0);
        chk("arst_insValid", 32'(insValid), 32'd0);
        chk("arst_ins", ins, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_imemAddr", imemAddr, 32'h0);
        imemAck  = 1'b0;
        insTaken = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bit          rd;
            logic [31:0] tgt;
            rd  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(rd, tgt, ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1));
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        chk("wrap_done", 32'(w_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
